// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the CPU memory-port arbiter.
package cpu_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: bit 0 = fetch port, bit 1 = data port.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] grant_c
);

  // On contention the port that did not own the last transaction wins.
  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (DM) ports,
// one transaction at a time, with a response timeout that completes hung reads with error.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  owner_t            last_owner, last_owner_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [1:0]        pick_c;
  logic              quiet_c;

  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              if_gnt_nxt, if_rvalid_nxt, if_err_nxt;
  logic              dm_gnt_nxt, dm_rvalid_nxt, dm_err_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;

  rr_arb2 u_arb (
    .req        ({dm_req, if_req}),
    .last_owner (last_owner),
    .grant_c    (pick_c)
  );

  // A requester still sees its gnt/rvalid this cycle and may not have dropped req yet.
  assign quiet_c = !(if_gnt || dm_gnt || if_rvalid || dm_rvalid);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    to_cnt_nxt     = to_cnt;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    if_gnt_nxt     = 1'b0;
    if_rvalid_nxt  = 1'b0;
    if_rdata_nxt   = '0;
    if_err_nxt     = 1'b0;
    dm_gnt_nxt     = 1'b0;
    dm_rvalid_nxt  = 1'b0;
    dm_rdata_nxt   = '0;
    dm_err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (quiet_c && (pick_c != 2'b00)) begin
          state_nxt   = REQ;
          mem_req_nxt = 1'b1;
          if (pick_c[1]) begin
            owner_nxt     = OWN_DM;
            mem_we_nxt    = dm_we;
            mem_addr_nxt  = dm_addr;
            mem_wdata_nxt = dm_wdata;
          end else begin
            owner_nxt     = OWN_IF;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = '0;
          end
        end
      end

      REQ: begin
        if (mem_ack) begin
          mem_req_nxt    = 1'b0;
          last_owner_nxt = owner;
          to_cnt_nxt     = '0;
          if (owner == OWN_DM) begin
            dm_gnt_nxt = 1'b1;
            if (mem_we) begin
              dm_rvalid_nxt = 1'b1;
              state_nxt     = IDLE;
            end else begin
              state_nxt = WAIT;
            end
          end else begin
            if_gnt_nxt = 1'b1;
            state_nxt  = WAIT;
          end
        end
      end

      WAIT: begin
        // Real data wins over a timeout landing on the same cycle.
        if (mem_rvalid) begin
          state_nxt = IDLE;
          if (owner == OWN_DM) begin
            dm_rvalid_nxt = 1'b1;
            dm_rdata_nxt  = mem_rdata;
          end else begin
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = mem_rdata;
          end
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          if (owner == OWN_DM) begin
            dm_rvalid_nxt = 1'b1;
            dm_err_nxt    = 1'b1;
          end else begin
            if_rvalid_nxt = 1'b1;
            if_err_nxt    = 1'b1;
          end
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, latches and all port outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      to_cnt     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_gnt     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      to_cnt     <= to_cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_gnt     <= if_gnt_nxt;
      if_rvalid  <= if_rvalid_nxt;
      if_rdata   <= if_rdata_nxt;
      if_err     <= if_err_nxt;
      dm_gnt     <= dm_gnt_nxt;
      dm_rvalid  <= dm_rvalid_nxt;
      dm_rdata   <= dm_rdata_nxt;
      dm_err     <= dm_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small configurable memory responder.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [18:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [18:0] if_rdata;
  logic        dm_req, dm_we;
  logic [18:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [18:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [18:0] mem_addr, mem_wdata;
  logic        mem_ack, mem_rvalid;
  logic [18:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Responder controls (written by tests only) and responder state.
  int ack_delay = 0;
  int rd_lat = 1;
  bit silent = 1'b0;
  int late_req = 0;
  int late_seen = 0;
  int req_cyc = 0;
  int rd_cnt = 0;
  logic [18:0] rd_data;

  int n_if_gnt = 0;
  int n_if_rvalid = 0;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .dm_err     (dm_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if_gnt)    n_if_gnt    <= n_if_gnt + 1;
    if (if_rvalid) n_if_rvalid <= n_if_rvalid + 1;
  end

  // Memory model: read data = addr ^ 0x11232.
  initial begin
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (late_req != late_seen) begin
        late_seen = late_req;
        mem_rvalid = 1'b1;
        mem_rdata = 19'h12345;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_data;
        end
      end
      if (mem_req) begin
        if (req_cyc >= ack_delay) begin
          mem_ack = 1'b1;
          req_cyc = 0;
          if (!mem_we && !silent) begin
            rd_cnt = rd_lat;
            rd_data = mem_addr ^ 19'h11232;
          end
        end else begin
          req_cyc++;
        end
      end else begin
        req_cyc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [83:0] outs;
    int t;
    int noisy;
    reset = 1'b0;
    tick(); tick();
    outs = {mem_req, mem_we, mem_addr, mem_wdata, if_gnt, if_rvalid, if_rdata, if_err,
            dm_gnt, dm_rvalid, dm_rdata, dm_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    reset = 1'b1;
    tick();
    // Park a fetch in WAIT, then reset asynchronously mid-cycle.
    silent = 1'b1;
    if_addr = 19'h2AAAA; if_req = 1'b1;
    t = 0;
    while (!if_gnt && t < 50) begin tick(); t++; end
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_setup_gnt: got %b, required 1", if_gnt);
    end
    if_req = 1'b0;
    tick(); tick();
    vectors++;
    if (mem_addr !== 19'h2AAAA) begin
      miscompares++;
      $display("FAIL reset_pre_addr: got %h, required 2aaaa", mem_addr);
    end
    #3 reset = 1'b0;
    #1;
    outs = {mem_req, mem_we, mem_addr, mem_wdata, if_gnt, if_rvalid, if_rdata, if_err,
            dm_gnt, dm_rvalid, dm_rdata, dm_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got %h, required 0", outs);
    end
    tick();
    reset = 1'b1;
    silent = 1'b0;
    noisy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet cycle %0d: got mem_req=%b if_rvalid=%b dm_rvalid=%b, required 0",
                 i, mem_req, if_rvalid, dm_rvalid);
      end
    end
  endtask

  task automatic test_lone_fetch();
    ack_delay = 0; rd_lat = 1;
    if_addr = 19'h00002; if_req = 1'b1;
    tick();
    vectors++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 19'h00002}) begin
      miscompares++;
      $display("FAIL fetch_mem_req: got req=%b we=%b addr=%h, required 1 0 00002",
               mem_req, mem_we, mem_addr);
    end
    tick();
    vectors++;
    if ({if_gnt, if_rvalid, dm_gnt} !== 3'b100) begin
      miscompares++;
      $display("FAIL fetch_gnt: got gnt=%b rvalid=%b dm_gnt=%b, required 1 0 0",
               if_gnt, if_rvalid, dm_gnt);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if ({if_gnt, if_rvalid, if_err, if_rdata} !== {1'b0, 1'b1, 1'b0, 19'h11230}) begin
      miscompares++;
      $display("FAIL fetch_rvalid: got gnt=%b rvalid=%b err=%b rdata=%h, required 0 1 0 11230",
               if_gnt, if_rvalid, if_err, if_rdata);
    end
    tick();
    vectors++;
    if ({if_rvalid, mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL fetch_after: got rvalid=%b mem_req=%b, required 0 0", if_rvalid, mem_req);
    end
  endtask

  task automatic test_contention();
    int order[$];
    int t;
    int last_c;
    bit prev_req;
    apply_reset();
    ack_delay = 0; rd_lat = 1;
    dm_we = 1'b0; dm_addr = 19'h00100; dm_wdata = '0; if_addr = 19'h00004;
    if_req = 1'b1; dm_req = 1'b1;
    t = 0; last_c = -1; prev_req = 1'b0;
    while (order.size() < 4 && t < 200) begin
      tick(); t++;
      if (if_gnt && dm_gnt) order.push_back(2);
      else if (dm_gnt) order.push_back(1);
      else if (if_gnt) order.push_back(0);
      if (dm_rvalid) begin
        vectors++;
        if ({dm_err, dm_rdata} !== {1'b0, 19'h11332}) begin
          miscompares++;
          $display("FAIL contend_dm_data: got err=%b rdata=%h, required 0 11332", dm_err, dm_rdata);
        end
        last_c = t;
      end
      if (if_rvalid) begin
        vectors++;
        if ({if_err, if_rdata} !== {1'b0, 19'h11236}) begin
          miscompares++;
          $display("FAIL contend_if_data: got err=%b rdata=%h, required 0 11236", if_err, if_rdata);
        end
        last_c = t;
      end
      if (mem_req && !prev_req && last_c >= 0) begin
        vectors++;
        if (t - last_c < 2) begin
          miscompares++;
          $display("FAIL contend_rearb_gap: got %0d cycles, required >= 2", t - last_c);
        end
      end
      prev_req = mem_req;
    end
    if_req = 1'b0; dm_req = 1'b0;
    vectors++;
    if (order.size() != 4) begin
      miscompares++;
      $display("FAIL contend_grant_count: got %0d, required 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (order[i] != ((i % 2 == 0) ? 1 : 0)) begin
          miscompares++;
          $display("FAIL contend_order[%0d]: got %0d, required %0d (1=DM 0=IF)",
                   i, order[i], (i % 2 == 0) ? 1 : 0);
        end
      end
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_store();
    ack_delay = 3;
    dm_we = 1'b1; dm_addr = 19'h00010; dm_wdata = 19'h7FFFF; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 19'h00010, 19'h7FFFF}) begin
        miscompares++;
        $display("FAIL store_hold cycle %0d: got req=%b we=%b addr=%h wdata=%h, required 1 1 00010 7ffff",
                 i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      vectors++;
      if ({dm_gnt, dm_rvalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL store_early_pulse cycle %0d: got gnt=%b rvalid=%b, required 0 0",
                 i, dm_gnt, dm_rvalid);
      end
    end
    tick();
    dm_req = 1'b0;
    vectors++;
    if ({dm_gnt, dm_rvalid, dm_err, dm_rdata, mem_req} !== {1'b1, 1'b1, 1'b0, 19'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL store_complete: got gnt=%b rvalid=%b err=%b rdata=%h mem_req=%b, required 1 1 0 0 0",
               dm_gnt, dm_rvalid, dm_err, dm_rdata, mem_req);
    end
    tick();
    tick();
    vectors++;
    if ({dm_gnt, dm_rvalid, mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL store_after: got gnt=%b rvalid=%b mem_req=%b, required 0 0 0",
               dm_gnt, dm_rvalid, mem_req);
    end
    ack_delay = 0;
  endtask

  task automatic test_timeout();
    int t;
    int early;
    int extra;
    silent = 1'b1;
    dm_we = 1'b0;
    if_addr = 19'h00040; if_req = 1'b1;
    t = 0;
    while (!if_gnt && t < 50) begin tick(); t++; end
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_gnt: got %b, required 1", if_gnt);
    end
    if_req = 1'b0;
    early = 0;
    for (int k = 1; k < 15; k++) begin
      tick();
      if (if_rvalid) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0d pulses, required 0", early);
    end
    tick();
    vectors++;
    if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b1, 19'h0}) begin
      miscompares++;
      $display("FAIL timeout_err: got rvalid=%b err=%b rdata=%h, required 1 1 0",
               if_rvalid, if_err, if_rdata);
    end
    late_req++;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if_rvalid || dm_rvalid || mem_req) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL timeout_late_data: got %0d activity cycles, required 0", extra);
    end
    silent = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t;
    int g0;
    int r0;
    rd_lat = 2; ack_delay = 0;
    g0 = n_if_gnt; r0 = n_if_rvalid;
    for (int pc = 0; pc < 8; pc++) begin
      if_addr = 19'(pc); if_req = 1'b1;
      t = 0;
      while (!if_gnt && t < 50) begin tick(); t++; end
      if_req = 1'b0;
      t = 0;
      while (!if_rvalid && t < 50) begin tick(); t++; end
      vectors++;
      if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 19'(pc) ^ 19'h11232}) begin
        miscompares++;
        $display("FAIL b2b_data pc=%0d: got rvalid=%b err=%b rdata=%h, required 1 0 %h",
                 pc, if_rvalid, if_err, if_rdata, 19'(pc) ^ 19'h11232);
      end
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (n_if_gnt - g0 != 8) begin
      miscompares++;
      $display("FAIL b2b_gnt_count: got %0d, required 8", n_if_gnt - g0);
    end
    vectors++;
    if (n_if_rvalid - r0 != 8) begin
      miscompares++;
      $display("FAIL b2b_rvalid_count: got %0d, required 8", n_if_rvalid - r0);
    end
    rd_lat = 1;
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_lone_fetch();
    test_contention();
    test_store();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
